// File: rtl/apb_slv_pkg.sv
// Shared types and bus widths for the APB4 completer memory.
package apb_slv_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = 4;

    localparam logic [APB_DW-1:0] APB_ERR_RDATA = 32'h0;

    typedef enum logic {
        APB_SLV_IDLE,
        APB_SLV_ACCESS
    } apb_slv_state_e;

    // Transfer attributes captured in the setup cycle
    typedef struct packed {
        logic write;
        logic err;
    } apb_slv_req_t;

endpackage

// File: rtl/apb_slv_bytemem.sv
// DEPTH x 32 flop array: per-byte write enable, async clear, combinational read.
module apb_slv_bytemem
    import apb_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [APB_SW-1:0]        wstrb,
    input  logic [APB_DW-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [APB_DW-1:0]        rdata_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [APB_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(APB_SW); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a register memory with wait states and PSLVERR.
// Define APB_SLV_PROT_CHECK_EN to reject unprivileged writes (PPROT[0]=0).
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned       MEM_DEPTH   = 256,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
    input  logic [APB_SW-1:0] PSTRB,
    input  logic [2:0]        PPROT,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned TAG_LSB = IDX_W + 2;

    apb_slv_state_e    state_q;
    apb_slv_req_t      req_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        wcnt_q;

    logic [IDX_W-1:0]  paddr_idx_c;
    logic [IDX_W-1:0]  raddr_c;
    logic [APB_DW-1:0] mem_rdata_c;
    logic [APB_SW-1:0] mem_strb_c;
    logic              in_win_c;
    logic              prot_err_c;
    logic              setup_err_c;
    logic              setup_c;
    logic              complete_c;
    logic              we_c;
    logic              resp_err_c;
    logic              resp_wr_c;
    logic [APB_DW-1:0] resp_rdata_c;
    logic              unused_c;

    assign paddr_idx_c = PADDR[IDX_W+1:2];
    assign in_win_c    = PADDR[APB_AW-1:TAG_LSB] == BASE_ADDR[APB_AW-1:TAG_LSB];

`ifdef APB_SLV_PROT_CHECK_EN
    assign prot_err_c = PWRITE && !PPROT[0];
`else
    assign prot_err_c = 1'b0;
`endif
    assign unused_c = ^PPROT;

    assign setup_err_c = !in_win_c || (PADDR[1:0] != 2'b00) || prot_err_c;
    assign setup_c     = PSEL && !PENABLE;
    assign complete_c  = (state_q == APB_SLV_ACCESS) && PREADY && PSEL && PENABLE;
    assign we_c        = complete_c && req_q.write && !req_q.err;
    assign mem_strb_c  = we_c ? PSTRB : '0;

    // Setup cycle reads via the live address; later cycles via the captured index
    assign raddr_c      = (state_q == APB_SLV_IDLE) ? paddr_idx_c : idx_q;
    assign resp_err_c   = (state_q == APB_SLV_IDLE) ? setup_err_c : req_q.err;
    assign resp_wr_c    = (state_q == APB_SLV_IDLE) ? PWRITE : req_q.write;
    assign resp_rdata_c = resp_err_c ? APB_ERR_RDATA : mem_rdata_c;

    apb_slv_bytemem #(
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .waddr   (idx_q),
        .wstrb   (mem_strb_c),
        .wdata   (PWDATA),
        .raddr   (raddr_c),
        .rdata_c (mem_rdata_c)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= APB_SLV_IDLE;
            req_q   <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state_q)
                APB_SLV_IDLE: begin
                    if (setup_c) begin
                        state_q <= APB_SLV_ACCESS;
                        idx_q   <= paddr_idx_c;
                        req_q   <= '{write: PWRITE, err: setup_err_c};
                        wcnt_q  <= 4'(WAIT_STATES);
                        PREADY  <= 1'(WAIT_STATES == 0);
                        if (WAIT_STATES == 0) begin
                            PSLVERR <= resp_err_c;
                            if (!resp_wr_c) PRDATA <= resp_rdata_c;
                        end
                    end
                end
                APB_SLV_ACCESS: begin
                    if (!PSEL) begin
                        state_q <= APB_SLV_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end else if (PREADY) begin
                        if (PENABLE) begin
                            state_q <= APB_SLV_IDLE;
                            PREADY  <= 1'b0;
                            PSLVERR <= 1'b0;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                        PREADY <= (wcnt_q == 4'd1);
                        if (wcnt_q == 4'd1) begin
                            PSLVERR <= resp_err_c;
                            if (!resp_wr_c) PRDATA <= resp_rdata_c;
                        end
                    end
                end
                default: state_q <= APB_SLV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with 0 and one with 3 wait states.
module tb_apb_slave_mem;

    logic        PCLK;
    logic        PRESETn;
    logic        psel0, psel3;
    logic        PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int checks = 0;
    int errors = 0;

    apb_slave_mem #(.BASE_ADDR(32'h0), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_slave_mem #(.BASE_ADDR(32'h0), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    // One full transfer; returns after sampling the PREADY cycle (completion edge is next)
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int cyc);
        @(posedge PCLK); #1;
        psel0 = (d == 0); psel3 = (d == 3); PENABLE = 1'b0;
        PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb; PPROT = prot;
        check("setup_pready", 32'(rdy(d)), 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 2;
        while (!rdy(d) && cyc < 40) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        check("pready_seen", 32'(rdy(d)), 32'd1);
        rdata = (d == 0) ? prdata0 : prdata3;
        err   = (d == 0) ? pslverr0 : pslverr3;
    endtask

    task automatic idle(input int d);
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
        check("idle_pready", 32'(rdy(d)), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          cy;

    initial begin
        PRESETn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = 3'b001;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_pready0", 32'(pready0), 32'd0);
        check("rst_pslverr0", 32'(pslverr0), 32'd0);
        check("rst_prdata0", prdata0, 32'h0);
        check("rst_pready3", 32'(pready3), 32'd0);
        check("rst_prdata3", prdata3, 32'h0);
        PRESETn = 1'b1;

        // Zero-wait write then back-to-back read
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cy);
        check("ws0_wr_err", 32'(er), 32'd0);
        check("ws0_wr_cyc", 32'(cy), 32'd2);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("ws0_rd_data", rd, 32'hDEADBEEF);
        check("ws0_rd_err", 32'(er), 32'd0);
        check("ws0_rd_cyc", 32'(cy), 32'd2);
        idle(0);

        // Three wait states, unwritten word
        xfer(3, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("ws3_rd_data", rd, 32'h0);
        check("ws3_rd_err", 32'(er), 32'd0);
        check("ws3_rd_cyc", 32'(cy), 32'd5);
        idle(3);

        // Byte strobes
        xfer(0, 1'b1, 32'h40, 32'h11223344, 4'hF, 3'b001, rd, er, cy);
        xfer(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er, cy);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("strb_merge", rd, 32'h11BB33DD);
        xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, cy);
        check("strb0_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("strb0_noop", rd, 32'h11BB33DD);

        // Error responses
        xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("oob_rd_err", 32'(er), 32'd1);
        check("oob_rd_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 3'b001, rd, er, cy);
        xfer(0, 1'b1, 32'h2, 32'hCAFEBABE, 4'hF, 3'b001, rd, er, cy);
        check("misalign_err", 32'(er), 32'd1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("misalign_keep", rd, 32'h01020304);
        check("misalign_rd_err", 32'(er), 32'd0);
        xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 3'b000, rd, er, cy);
        check("last_word_err", 32'(er), 32'd0);
        check("last_word_data", rd, 32'h0);

        // Unprivileged write
        xfer(0, 1'b1, 32'h80, 32'h5A5A5A5A, 4'hF, 3'b000, rd, er, cy);
`ifdef APB_SLV_PROT_CHECK_EN
        check("prot_wr_err", 32'(er), 32'd1);
`else
        check("prot_wr_err", 32'(er), 32'd0);
`endif
        xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, rd, er, cy);
`ifdef APB_SLV_PROT_CHECK_EN
        check("prot_rd_data", rd, 32'h0);
`else
        check("prot_rd_data", rd, 32'h5A5A5A5A);
`endif
        idle(0);

        // PSEL dropped mid-ACCESS on the wait-state instance
        xfer(3, 1'b1, 32'h30, 32'h77777777, 4'hF, 3'b001, rd, er, cy);
        idle(3);
        @(posedge PCLK); #1;
        psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30;
        PWDATA = 32'h99999999; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        psel3 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("abort_pready", 32'(pready3), 32'd0);
        xfer(3, 1'b0, 32'h30, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("abort_nowrite", rd, 32'h77777777);
        check("abort_next_cyc", 32'(cy), 32'd5);
        idle(3);

        // Reset asserted during the access phase of a write
        @(posedge PCLK); #1;
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h50;
        PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        check("prerst_pready", 32'(pready0), 32'd1);
        #1 PRESETn = 1'b0;
        #1;
        check("rst_async_pready", 32'(pready0), 32'd0);
        check("rst_async_prdata", prdata0, 32'h0);
        psel0 = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        xfer(0, 1'b0, 32'h50, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("rst_no_partial", rd, 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, cy);
        check("rst_mem_clear", rd, 32'h0);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB4 completer RTL backed by a word-addressed register memory, the responder-side DUT that the master-driver agent drives and that the slave-monitor agent observes. The block decodes its address window and applies byte strobes on writes. It returns registered read data, inserts a configurable number of wait states, and signals PSLVERR on illegal accesses.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base address of the window; must be aligned to 4*MEM_DEPTH.
- MEM_DEPTH, 256: number of 32-bit words, power of two, range 16..1024.
- WAIT_STATES, 0: access-phase wait cycles before PREADY, range 0..15.
- PCLK  input  1  APB clock; all logic is on the rising edge.
- PRESETn  input  1  asynchronous active-low reset. Deassertion is synchronous to PCLK externally.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  32  byte address.
- PWDATA  input  32  write data.
- PSTRB  input  4  write byte-lane enables.
- PPROT  input  3  protection attributes; bit 0 = privileged.
- PRDATA  output  32  read data, registered.
- PREADY  output  1  transfer-complete, registered.
- PSLVERR  output  1  error response, registered, meaningful only when PREADY=1.

## Operation
- FSM states: IDLE and ACCESS, with a 4-bit wait counter wcnt.
- IDLE → ACCESS on an edge sampling PSEL=1 && PENABLE=0. Capture the address index, PWRITE and the error flag, set wcnt=WAIT_STATES, and set PREADY <= (WAIT_STATES==0).
- ACCESS with PREADY=0 and PSEL=1: decrement wcnt. PREADY <= (wcnt==1).
- ACCESS with PREADY=1 and PSEL=PENABLE=1: the transfer completes. Commit the write if error-free, go to IDLE, and clear PREADY and PSLVERR to 0.
- ACCESS with PSEL=0 (protocol violation): abort to IDLE. No write occurs, and PREADY and PSLVERR go to 0.
- Error conditions are evaluated at setup:
  - PADDR outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH)
  - PADDR[1:0] != 0
  - the protection check (see Configuration)
- Error response: PSLVERR=1 together with PREADY=1. An erroring write leaves memory unchanged; an erroring read returns PRDATA=0.
- Index = PADDR[$clog2(MEM_DEPTH)+1:2].
- Write: byte lane k updates only if PSTRB[k]=1. PSTRB=0 is a legal no-op that completes with OKAY.
- Read: PSTRB is ignored. PRDATA is loaded from memory on the same edge that sets PREADY=1.
- PRDATA holds its last value otherwise.
- Memory contents clear to 0 on reset.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wcnt=0, all memory words 0.
- Assertion of PRESETn mid-transfer aborts immediately: no partial write, and outputs return to reset values asynchronously.
- Transfer length is WAIT_STATES+2 cycles: one setup cycle plus WAIT_STATES+1 access cycles. PREADY is high only in the final access cycle.
- A write commits at the completion edge and is visible to a read whose setup phase starts in the next cycle.
- Back-to-back transfers (setup immediately after completion) are supported with no idle cycle.
- PREADY is never high in IDLE or during the setup cycle.

## Configuration
- APB_SLV_PROT_CHECK_EN, when defined: a write with PPROT[0]=0 (unprivileged) is an error, so PSLVERR=1 and memory is unchanged. Reads are unaffected.
- Without the macro, PPROT is ignored entirely.

## Structure
- Package apb_slv_pkg holds:
  - the state enum (APB_SLV_IDLE, APB_SLV_ACCESS)
  - the bus widths (APB_AW=32, APB_DW=32, APB_SW=4)
  - the error read value APB_ERR_RDATA=32'h0
- Sub-module apb_slv_bytemem is a MEM_DEPTH x 32 flop array with per-byte write enable, an asynchronous reset clear, and a combinational read port. apb_slave_mem holds the FSM, decode and output registers.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to BASE+0x10 with PSTRB=4'hF, then read BASE+0x10 → PRDATA=0xDEADBEEF, PSLVERR=0, each transfer exactly 2 cycles.
- WAIT_STATES=3: read of an unwritten word → PREADY high only in the 4th access cycle (5-cycle transfer), PRDATA=0.
- Byte strobes: write 0x11223344 with PSTRB=4'hF, then write 0xAABBCCDD with PSTRB=4'b0101, then read → 0x11BB33DD.
- Errors: read BASE+4*MEM_DEPTH → PSLVERR=1, PRDATA=0. Write to BASE+0x2 → PSLVERR=1, target word unchanged. With APB_SLV_PROT_CHECK_EN, a write with PPROT=3'b000 → PSLVERR=1, memory unchanged.
- Reset mid-transfer: assert PRESETn=0 during the access phase of a write → PREADY=0 immediately; after release, a read of that address returns 0.
- Back-to-back write then read, plus PSEL dropped mid-ACCESS → the abort performs no write, and the next transfer completes normally.
